vga_code_fetch: RTL and testbench

VGA_CODE_FETCH -- requirements
Module: vga_code_fetch

---
 rtl/vga_code_fetch_if.sv | 17 +
 rtl/vga_code_fetch.sv | 135 +++++++++++++
 tb/tb_vga_code_fetch.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/vga_code_fetch_if.sv
// Frame-buffer read port: registered address out, colour code back one enabled cycle later.
interface vga_code_fetch_if;
  logic [14:0] MEM_ADDR;
  logic [7:0]  MEM_DATA;

  // Fetch side drives the address and consumes the returned code.
  modport master (
    output MEM_ADDR,
    input  MEM_DATA
  );

  // Frame-buffer side returns the code for the presented address.
  modport slave (
    input  MEM_ADDR,
    output MEM_DATA
  );
endinterface

// File: rtl/vga_code_fetch.sv
// VGA timing generator and frame-buffer fetch pipeline for a 4x4-upscaled 160x120 image.
// Stage 0 is the h/v counter pair; the address is registered at +1, the frame buffer
// returns data at +2 and the colour code plus sync/enable flags leave at +3.
module vga_code_fetch #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter logic [7:0]  BLANK_CODE = 8'hFE
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    PIX_EN,
  vga_code_fetch_if.master        mem,
  output logic [7:0]              CODE,
  output logic                    HSYNC_N,
  output logic                    VSYNC_N,
  output logic                    DE,
  output logic                    FRAME_START
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

  // Stage 0: raster counters
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic [HW-1:0] w_h_next;
  logic [VW-1:0] w_v_next;

  // Stage-0 decode
  logic          w_active;
  logic          w_hsync_n;
  logic          w_vsync_n;
  logic          w_first;
  logic [14:0]   w_hq;
  logic [14:0]   w_vq;
  logic [14:0]   w_addr;

  // Stage 1 (aligned with MEM_ADDR) and stage 2 (aligned with MEM_DATA)
  logic [14:0]   r_mem_addr;
  logic          r_act1, r_hs1, r_vs1, r_first1;
  logic          r_act2, r_hs2, r_vs2, r_first2;

  // Stage 3: outputs
  logic [7:0]    r_code;
  logic          r_de, r_hs, r_vs, r_fs;

  // Raster counter advance with line and frame wrap
  always_comb begin
    w_h_next = r_h + HW'(1);
    w_v_next = r_v;
    if (r_h == H_LAST) begin
      w_h_next = '0;
      if (r_v == V_LAST) begin
        w_v_next = '0;
      end else begin
        w_v_next = r_v + VW'(1);
      end
    end
  end

  // Stage-0 flags and frame-buffer address; x160 done as shift-and-add
  always_comb begin
    w_active  = (r_h < H_ACT) && (r_v < V_ACT);
    w_hsync_n = !((r_h >= H_SS) && (r_h < H_SE));
    w_vsync_n = !((r_v >= V_SS) && (r_v < V_SE));
    w_first   = (r_h == '0) && (r_v == '0);
    w_hq      = 15'(r_h >> 2);
    w_vq      = 15'(r_v >> 2);
    w_addr    = w_active ? ((w_vq << 7) + (w_vq << 5) + w_hq) : 15'd0;
  end

  // Whole pipeline: synchronous reset wins over PIX_EN; PIX_EN=0 freezes everything
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_h        <= '0;
      r_v        <= '0;
      r_mem_addr <= '0;
      r_act1     <= 1'b0;
      r_hs1      <= 1'b1;
      r_vs1      <= 1'b1;
      r_first1   <= 1'b0;
      r_act2     <= 1'b0;
      r_hs2      <= 1'b1;
      r_vs2      <= 1'b1;
      r_first2   <= 1'b0;
      r_code     <= BLANK_CODE;
      r_de       <= 1'b0;
      r_hs       <= 1'b1;
      r_vs       <= 1'b1;
      r_fs       <= 1'b0;
    end else if (PIX_EN) begin
      r_h        <= w_h_next;
      r_v        <= w_v_next;
      r_mem_addr <= w_addr;
      r_act1     <= w_active;
      r_hs1      <= w_hsync_n;
      r_vs1      <= w_vsync_n;
      r_first1   <= w_first;
      r_act2     <= r_act1;
      r_hs2      <= r_hs1;
      r_vs2      <= r_vs1;
      r_first2   <= r_first1;
      r_code     <= r_act2 ? mem.MEM_DATA : BLANK_CODE;
      r_de       <= r_act2;
      r_hs       <= r_hs2;
      r_vs       <= r_vs2;
      r_fs       <= r_first2;
    end
  end

  assign mem.MEM_ADDR = r_mem_addr;
  assign CODE         = r_code;
  assign DE           = r_de;
  assign HSYNC_N      = r_hs;
  assign VSYNC_N      = r_vs;
  assign FRAME_START  = r_fs;

endmodule

// File: tb/tb_vga_code_fetch.sv
// Bench: full-size DUT for line/address behaviour, shrunken-timing DUT for frame behaviour.
module tb_vga_code_fetch;

  logic CLK = 1'b0;
  logic RESET_N;
  logic PIX_EN;

  always #5 CLK = ~CLK;

  vga_code_fetch_if u_bus ();
  vga_code_fetch_if u_sbus ();

  logic [7:0] code, s_code;
  logic       hs, vs, de, fs;
  logic       s_hs, s_vs, s_de, s_fs;

  vga_code_fetch u_dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .PIX_EN      (PIX_EN),
    .mem         (u_bus.master),
    .CODE        (code),
    .HSYNC_N     (hs),
    .VSYNC_N     (vs),
    .DE          (de),
    .FRAME_START (fs)
  );

  // 24 x 16 raster: 16x12 active, hsync 18..21, vsync lines 13..14, 384 per frame
  vga_code_fetch #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (2),
    .V_ACTIVE (12), .V_FP (1), .V_SYNC (2), .V_BP (1)
  ) u_sml (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .PIX_EN      (PIX_EN),
    .mem         (u_sbus.master),
    .CODE        (s_code),
    .HSYNC_N     (s_hs),
    .VSYNC_N     (s_vs),
    .DE          (s_de),
    .FRAME_START (s_fs)
  );

  // Model ROM contents: code = 3*addr + 1 (mod 256)
  function automatic logic [7:0] rom(input logic [14:0] a);
    return 8'(a * 15'd3 + 15'd1);
  endfunction

  logic [7:0] r_rom_q  = 8'h00;
  logic [7:0] r_srom_q = 8'h00;

  // Synchronous frame buffers advancing on the pixel enable
  always @(posedge CLK) begin
    if (PIX_EN) begin
      r_rom_q  <= rom(u_bus.MEM_ADDR);
      r_srom_q <= rom(u_sbus.MEM_ADDR);
    end
  end

  assign u_bus.MEM_DATA  = r_rom_q;
  assign u_sbus.MEM_DATA = r_srom_q;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected outputs after n enabled edges following reset release (hand-derived)
  logic [14:0] exp_addr [0:10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 2};
  logic [7:0]  exp_code [0:10] = '{8'hFE, 8'hFE, 8'hFE, 8'h01, 8'h01, 8'h01, 8'h01,
                                   8'h04, 8'h04, 8'h04, 8'h04};
  logic        exp_de   [0:10] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
  logic        exp_fs   [0:10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};

  task automatic check_early(input string ph, input int n);
    check_eq($sformatf("%s addr n=%0d", ph, n), 32'(u_bus.MEM_ADDR), 32'(exp_addr[n]));
    check_eq($sformatf("%s code n=%0d", ph, n), 32'(code), 32'(exp_code[n]));
    check_eq($sformatf("%s de n=%0d", ph, n), 32'(de), 32'(exp_de[n]));
    check_eq($sformatf("%s fs n=%0d", ph, n), 32'(fs), 32'(exp_fs[n]));
    check_eq($sformatf("%s hs n=%0d", ph, n), 32'(hs), 32'd1);
    check_eq($sformatf("%s vs n=%0d", ph, n), 32'(vs), 32'd1);
  endtask

  task automatic check_reset(input string ph);
    check_eq({ph, " rst addr"}, 32'(u_bus.MEM_ADDR), 32'd0);
    check_eq({ph, " rst code"}, 32'(code), 32'hFE);
    check_eq({ph, " rst de"}, 32'(de), 32'd0);
    check_eq({ph, " rst hs"}, 32'(hs), 32'd1);
    check_eq({ph, " rst vs"}, 32'(vs), 32'd1);
    check_eq({ph, " rst fs"}, 32'(fs), 32'd0);
    check_eq({ph, " rst s_addr"}, 32'(u_sbus.MEM_ADDR), 32'd0);
    check_eq({ph, " rst s_code"}, 32'(s_code), 32'hFE);
  endtask

  // One clock; samples are taken on the falling edge
  task automatic clk_step();
    @(negedge CLK);
  endtask

  int de_cnt, hs_cnt, hs_first, de_fall, de_rise2, fs_cnt, viol;
  int s_de_cnt, s_vs_cnt, s_vs_first, s_fs_win, s_fs_cnt, s_viol;
  int n;

  initial begin
    de_cnt = 0; hs_cnt = 0; hs_first = 0; de_fall = 0; de_rise2 = 0; fs_cnt = 0; viol = 0;
    s_de_cnt = 0; s_vs_cnt = 0; s_vs_first = 0; s_fs_win = 0; s_fs_cnt = 0; s_viol = 0;

    // Reset with enable both low and high
    RESET_N = 1'b0;
    PIX_EN  = 1'b0;
    clk_step();
    PIX_EN  = 1'b1;
    clk_step();
    check_reset("init");

    // Continuous enable run
    RESET_N = 1'b1;
    n = 0;
    for (int k = 1; k <= 4300; k++) begin
      clk_step();
      n = k;
      if (n <= 10) check_early("run", n);
      if (de && (!hs || !vs)) viol++;
      if (s_de && (!s_hs || !s_vs)) s_viol++;
      if (fs) fs_cnt++;
      if (s_fs) s_fs_cnt++;
      if (n >= 3 && n <= 802) begin
        if (de) de_cnt++;
        if (!hs) hs_cnt++;
        if (!hs && hs_first == 0) hs_first = n;
        if (!de && de_fall == 0) de_fall = n;
      end
      if (n > 802 && de && de_rise2 == 0) de_rise2 = n;
      if (n >= 3 && n <= 386) begin
        if (s_de) s_de_cnt++;
        if (!s_vs) s_vs_cnt++;
        if (!s_vs && s_vs_first == 0) s_vs_first = n;
        if (s_fs) s_fs_win++;
      end
      if (n == 640)  check_eq("addr h639 v0", 32'(u_bus.MEM_ADDR), 32'd159);
      if (n == 641)  check_eq("addr h640 blank", 32'(u_bus.MEM_ADDR), 32'd0);
      if (n == 700)  check_eq("code hblank", 32'(code), 32'hFE);
      if (n == 3201) check_eq("addr line4 start", 32'(u_bus.MEM_ADDR), 32'd160);
      if (n == 3203) check_eq("code line4 start", 32'(code), 32'hE1);
      if (n == 4001) check_eq("addr line5 start", 32'(u_bus.MEM_ADDR), 32'd160);
      if (n == 4100) check_eq("addr h99 v5", 32'(u_bus.MEM_ADDR), 32'd184);
      if (n == 280)  check_eq("s addr last pixel", 32'(u_sbus.MEM_ADDR), 32'd323);
      if (n == 281)  check_eq("s addr blank", 32'(u_sbus.MEM_ADDR), 32'd0);
      if (n == 387)  check_eq("s fs frame2", 32'(s_fs), 32'd1);
    end
    check_eq("line de count", 32'(de_cnt), 32'd640);
    check_eq("line hs count", 32'(hs_cnt), 32'd96);
    check_eq("hs after de fall", 32'(hs_first - de_fall), 32'd16);
    check_eq("line period", 32'(de_rise2 - 3), 32'd800);
    check_eq("fs count big", 32'(fs_cnt), 32'd1);
    check_eq("de in sync big", 32'(viol), 32'd0);
    check_eq("s frame de count", 32'(s_de_cnt), 32'd192);
    check_eq("s frame vs count", 32'(s_vs_cnt), 32'd48);
    check_eq("s vs start", 32'(s_vs_first), 32'd315);
    check_eq("s fs per frame", 32'(s_fs_win), 32'd1);
    check_eq("s fs total", 32'(s_fs_cnt), 32'd12);
    check_eq("de in sync small", 32'(s_viol), 32'd0);

    // Mid-frame reset at h=300, v=5 with the enable high
    RESET_N = 1'b0;
    clk_step();
    check_reset("mid");
    RESET_N = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      clk_step();
      check_early("restart", k);
    end

    // Enable toggled 1,0,1,0: disabled cycles must hold the last enabled values
    RESET_N = 1'b0;
    clk_step();
    RESET_N = 1'b1;
    n = 0;
    for (int i = 0; i < 22; i++) begin
      PIX_EN = (i % 2 == 0);
      clk_step();
      if (PIX_EN) n++;
      if (n <= 10) check_early(PIX_EN ? "tog_en" : "tog_hold", n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
